// File: rtl/pgr_apb_arb_pkg.sv
// Shared constants for the pgr_apb_arb_32bit APB arbiter/sequencer.
// State encoding, timeout read-data pattern and default timeout length.
package pgr_apb_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  localparam int TO_CYCLES_DEFAULT = 1024;

endpackage

// File: rtl/pgr_rr_arb.sv
// Combinational round-robin picker: grants the first requester strictly
// after the last-granted index, wrapping circularly.
module pgr_rr_arb #(
  parameter int NM = 2,
  parameter int LW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req,
  input  logic [LW-1:0] last,
  output logic [LW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [LW-1:0] cand [NM];

  // cand[k] is the index k+1 positions after last, i.e. k-th in priority order
  for (genvar gi = 0; gi < NM; gi++) begin : g_cand
    assign cand[gi] = LW'((int'(last) + gi + 1) % NM);
  end

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = NM - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        gnt_idx = cand[k];
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pgr_apb_arb_32bit.sv
// Round-robin arbiter + APB SETUP/ACCESS sequencer sharing one APB slave
// bus among NM masters. Optional ACCESS timeout: PGR_APB_ARB_TIMEOUT_EN.
module pgr_apb_arb_32bit
  import pgr_apb_arb_pkg::*;
#(
  parameter int NM        = 2,
  parameter int AW        = 16,
  parameter int DW        = 32,
  parameter int SW        = 4,
  parameter int TO_CYCLES = TO_CYCLES_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NM-1:0]    m_req,
  input  logic [NM-1:0]    m_we,
  input  logic [NM*AW-1:0] m_addr,
  input  logic [NM*DW-1:0] m_wdata,
  input  logic [NM*SW-1:0] m_strb,
  output logic [NM-1:0]    m_done,
  output logic [NM-1:0]    m_err,
  output logic [DW-1:0]    m_rdata,
  output logic             p_sel,
  output logic [SW-1:0]    p_strb,
  output logic [AW-1:0]    p_addr,
  output logic [DW-1:0]    p_wdata,
  output logic             p_ce,
  output logic             p_we,
  input  logic             p_rdy,
  input  logic [DW-1:0]    p_rdata
);

  localparam int LW = (NM > 1) ? $clog2(NM) : 1;

  logic [1:0]    state_reg, state_next;
  logic [LW-1:0] last_reg;
  logic [LW-1:0] gnt_idx;
  logic          gnt_vld;
  logic          p_we_reg;
  logic [AW-1:0] p_addr_reg;
  logic [DW-1:0] p_wdata_reg;
  logic [SW-1:0] p_strb_reg;
  logic [DW-1:0] m_rdata_reg;
  logic          to_hit;

  pgr_rr_arb #(.NM(NM), .LW(LW)) u_rr_arb (
    .req     (m_req),
    .last    (last_reg),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

`ifdef PGR_APB_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TO_CYCLES) > 0) ? $clog2(TO_CYCLES) : 1;
  localparam logic [DW-1:0] ERR_RDATA_DW = DW'(ERR_RDATA);

  logic [CW-1:0] to_cnt_reg;
  logic          err_reg;

  assign to_hit = (to_cnt_reg == CW'(TO_CYCLES - 1));

  // Counter restarts in SETUP so it reads 0 on the first ACCESS cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (state_reg == ST_SETUP) begin
        to_cnt_reg <= '0;
      end else if (state_reg == ST_ACCESS) begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end
      if (state_reg == ST_ACCESS) begin
        err_reg <= !p_rdy && to_hit;
      end
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // State register plus the registered copy of the granted command
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      last_reg    <= LW'(NM - 1);
      p_we_reg    <= 1'b0;
      p_addr_reg  <= '0;
      p_wdata_reg <= '0;
      p_strb_reg  <= '0;
      m_rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (gnt_vld) begin
            last_reg    <= gnt_idx;
            p_we_reg    <= m_we[gnt_idx];
            p_addr_reg  <= m_addr[gnt_idx*AW +: AW];
            p_wdata_reg <= m_wdata[gnt_idx*DW +: DW];
            p_strb_reg  <= m_strb[gnt_idx*SW +: SW];
          end
        end
        ST_ACCESS: begin
          if (p_rdy) begin
            m_rdata_reg <= p_rdata;
          end
`ifdef PGR_APB_ARB_TIMEOUT_EN
          else if (to_hit) begin
            m_rdata_reg <= ERR_RDATA_DW;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (gnt_vld) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (p_rdy || to_hit) state_next = ST_DONE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    p_sel  = 1'b0;
    p_ce   = 1'b0;
    m_done = '0;
    m_err  = '0;
    case (state_reg)
      ST_SETUP:  p_sel = 1'b1;
      ST_ACCESS: begin
        p_sel = 1'b1;
        p_ce  = 1'b1;
      end
      ST_DONE: begin
        m_done[last_reg] = 1'b1;
`ifdef PGR_APB_ARB_TIMEOUT_EN
        m_err[last_reg] = err_reg;
`endif
      end
      default: ;
    endcase
  end

  assign p_we    = p_we_reg;
  assign p_addr  = p_addr_reg;
  assign p_wdata = p_wdata_reg;
  assign p_strb  = p_strb_reg;
  assign m_rdata = m_rdata_reg;

endmodule

// File: tb/tb_pgr_apb_arb_32bit.sv
// Directed bench for pgr_apb_arb_32bit: behavioural APB slave, scoreboard of
// expected completions, and latency/ordering/reset/timeout checks.
module tb_pgr_apb_arb_32bit;

  localparam int NM = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NM-1:0]    m_req;
  logic [NM-1:0]    m_we;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM*SW-1:0] m_strb;
  logic [NM-1:0]    m_done;
  logic [NM-1:0]    m_err;
  logic [DW-1:0]    m_rdata;
  logic             p_sel;
  logic [SW-1:0]    p_strb;
  logic [AW-1:0]    p_addr;
  logic [DW-1:0]    p_wdata;
  logic             p_ce;
  logic             p_we;
  logic             p_rdy = 1'b0;
  logic [DW-1:0]    p_rdata = '0;

  int checks = 0;
  int errors = 0;
  int wait_n = 0;
  int acc_cnt = 0;

  typedef struct {
    int          m;
    logic [31:0] rd;
    bit          chk_rd;
    bit          err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pgr_apb_arb_32bit #(.NM(NM), .AW(AW), .DW(DW), .SW(SW), .TO_CYCLES(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_strb  (m_strb),
    .m_done  (m_done),
    .m_err   (m_err),
    .m_rdata (m_rdata),
    .p_sel   (p_sel),
    .p_strb  (p_strb),
    .p_addr  (p_addr),
    .p_wdata (p_wdata),
    .p_ce    (p_ce),
    .p_we    (p_we),
    .p_rdy   (p_rdy),
    .p_rdata (p_rdata)
  );

  function automatic logic [31:0] slave_data(input logic [15:0] a);
    if (a == 16'h0010) return 32'h1234_5678;
    return {a, ~a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int m, input bit we, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    m_we[m]             = we;
    m_addr[m*AW +: AW]  = a;
    m_wdata[m*DW +: DW] = d;
    m_strb[m*SW +: SW]  = s;
  endtask

  // APB slave: ready after wait_n stalled ACCESS cycles
  always @(negedge clk) begin
    if (p_sel && p_ce) acc_cnt++;
    else acc_cnt = 0;
    p_rdy   = p_sel && p_ce && (acc_cnt > wait_n);
    p_rdata = slave_data(p_addr);
  end

  // Scoreboard: every completion must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && m_done != '0) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", m_done, 0);
      end else begin
        exp_t e;
        logic [1:0] exp_bit;
        e = sb.pop_front();
        exp_bit = 2'b01 << e.m;
        chk("sb_done", m_done, exp_bit);
        chk("sb_err", m_err, e.err ? exp_bit : 2'b00);
        if (e.chk_rd) chk("sb_rdata", m_rdata, e.rd);
        $display("done: master=%0d rdata=%08h err=%0b", e.m, m_rdata, m_err != 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    int done_k;
    int order[6];

    rst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_strb = '0;
    repeat (3) @(negedge clk);
    chk("rst_bus", {p_sel, p_ce, p_we, m_done, m_err}, 0);
    chk("rst_addr", p_addr, 0);
    chk("rst_wdata_strb", {p_wdata, p_strb}, 0);
    chk("rst_rdata", m_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single read from master 0, rdy on first ACCESS cycle
    wait_n = 0;
    set_cmd(0, 0, 16'h0010, 32'h0, 4'hF);
    m_req = 2'b01;
    sb.push_back('{m: 0, rd: 32'h1234_5678, chk_rd: 1'b1, err: 1'b0});
    @(negedge clk);
    chk("t1_setup", {p_sel, p_ce}, 2'b10);
    chk("t1_addr", p_addr, 16'h0010);
    chk("t1_we", p_we, 0);
    @(negedge clk);
    chk("t1_access", {p_sel, p_ce}, 2'b11);
    @(negedge clk);
    chk("t1_done_t3", m_done, 2'b01);
    chk("t1_done_bus", {p_sel, p_ce}, 2'b00);
    m_req = 2'b00;
    @(negedge clk);
    chk("t1_idle", {p_sel, p_ce, m_done}, 0);
    chk("t1_rdata_hold", m_rdata, 32'h1234_5678);

    // Write from master 1 with 5 wait states
    wait_n = 5;
    set_cmd(1, 1, 16'h0200, 32'hA5A5_0F0F, 4'b0011);
    m_req = 2'b10;
    sb.push_back('{m: 1, rd: 32'h0, chk_rd: 1'b0, err: 1'b0});
    n_done = 0; done_k = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (p_ce) begin
        chk("t2_addr", p_addr, 16'h0200);
        chk("t2_wdata", p_wdata, 32'hA5A5_0F0F);
        chk("t2_strb_we", {p_strb, p_we}, 5'b0011_1);
      end
      if (m_done != '0) begin
        n_done++; done_k = k; m_req = 2'b00;
      end
    end
    chk("t2_done_cycle", done_k, 8);
    chk("t2_done_count", n_done, 1);

    // Contention: both masters request continuously for 6 transfers
    wait_n = 0;
    set_cmd(0, 0, 16'h0100, 32'h0, 4'hF);
    set_cmd(1, 1, 16'h0104, 32'h1111_2222, 4'hF);
    for (int i = 0; i < 6; i++)
      sb.push_back('{m: i % 2, rd: slave_data(16'h0100), chk_rd: (i % 2 == 0), err: 1'b0});
    m_req = 2'b11;
    n_done = 0;
    for (int k = 0; k < 60 && n_done < 6; k++) begin
      @(negedge clk);
      if (m_done != '0) begin
        order[n_done] = (m_done == 2'b10) ? 1 : 0;
        n_done++;
        if (n_done == 6) m_req = 2'b00;
      end
    end
    chk("t3_transfers", n_done, 6);
    for (int i = 1; i < 6; i++) chk("t3_alternate", order[i] != order[i-1], 1);
    @(negedge clk);

    // Reset during ACCESS of a master-0 transfer (pointer would favour master 1)
    wait_n = 100;
    set_cmd(0, 0, 16'h0300, 32'h0, 4'hF);
    m_req = 2'b01;
    n_done = 0;
    for (int k = 0; k < 10 && !p_ce; k++) @(negedge clk);
    chk("t4_in_access", p_ce, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_bus", {p_sel, p_ce, p_we, m_done, m_err}, 0);
    chk("t4_rst_addr", p_addr, 0);
    rst = 1'b0; m_req = 2'b00;
    repeat (3) @(negedge clk);
    wait_n = 0;
    set_cmd(0, 0, 16'h0400, 32'h0, 4'hF);
    set_cmd(1, 0, 16'h0500, 32'h0, 4'hF);
    sb.push_back('{m: 0, rd: slave_data(16'h0400), chk_rd: 1'b1, err: 1'b0});
    sb.push_back('{m: 1, rd: slave_data(16'h0500), chk_rd: 1'b1, err: 1'b0});
    m_req = 2'b11;
    for (int k = 0; k < 30 && n_done < 2; k++) begin
      @(negedge clk);
      if (m_done != '0) begin
        m_req = m_req & ~m_done;
        n_done++;
      end
    end
    chk("t4_after_rst_dones", n_done, 2);
    @(negedge clk);

`ifdef PGR_APB_ARB_TIMEOUT_EN
    // Slave never ready: timeout after TO ACCESS cycles
    wait_n = 1000;
    set_cmd(0, 0, 16'h0030, 32'h0, 4'hF);
    m_req = 2'b01;
    sb.push_back('{m: 0, rd: 32'hDEAD_BEEF, chk_rd: 1'b1, err: 1'b1});
    done_k = 0;
    for (int k = 1; k <= 40 && done_k == 0; k++) begin
      @(negedge clk);
      if (m_done != '0) begin done_k = k; m_req = 2'b00; end
    end
    chk("t5_timeout_cycle", done_k, TO + 2);
    @(negedge clk);

    // Ready on the final timeout cycle: ready wins
    wait_n = TO - 1;
    set_cmd(0, 0, 16'h0034, 32'h0, 4'hF);
    m_req = 2'b01;
    sb.push_back('{m: 0, rd: slave_data(16'h0034), chk_rd: 1'b1, err: 1'b0});
    done_k = 0;
    for (int k = 1; k <= 40 && done_k == 0; k++) begin
      @(negedge clk);
      if (m_done != '0) begin done_k = k; m_req = 2'b00; end
    end
    chk("t6_rdy_wins_cycle", done_k, TO + 2);
    @(negedge clk);
`else
    // Without timeout the bus stays in ACCESS indefinitely
    wait_n = 1000;
    set_cmd(0, 0, 16'h0030, 32'h0, 4'hF);
    m_req = 2'b01;
    repeat (100) @(negedge clk);
    chk("t5_still_access", {p_sel, p_ce, m_done, m_err}, 6'b11_00_00);
    rst = 1'b1; m_req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pgr_apb_arb_32bit.md
Name: pgr_apb_arb_32bit

Overview:
- Round-robin arbiter and APB sequencer that shares one 32-bit APB slave bus between NM command masters.
- Masters are, for example, the UART command bridge and the PCIe-side register master.
- Each master issues a level request with its address, data, strobe and direction. The block grants one master, runs a SETUP/ACCESS APB transfer, and returns read data plus a one-cycle done pulse to that master.
- Sits between the command-parsing masters and the p_* APB bus of the example design.

Parameters:
- NM, 2, number of masters (2..8).
- AW, 16, APB address width.
- DW, 32, APB data width.
- SW, 4, strobe width (DW/8).
- TO_CYCLES, 1024, ACCESS-phase timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- m_req  in  NM  per-master request level; bit i = master i.
- m_we  in  NM  per-master write(1)/read(0).
- m_addr  in  NM*AW  packed addresses; master i at [i*AW +: AW].
- m_wdata  in  NM*DW  packed write data.
- m_strb  in  NM*SW  packed byte strobes.
- m_done  out  NM  one-cycle completion pulse to the granted master.
- m_err  out  NM  one-cycle error flag, coincident with m_done.
- m_rdata  out  DW  read data; valid while any m_done bit is high.
- p_sel  out  1  APB select.
- p_strb  out  SW  APB strobe.
- p_addr  out  AW  APB address.
- p_wdata  out  DW  APB write data.
- p_ce  out  1  APB enable (access phase).
- p_we  out  1  APB write.
- p_rdy  in  1  APB ready.
- p_rdata  in  DW  APB read data.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
- Reset:
  - All outputs 0, state IDLE.
  - Last-grant pointer = NM-1, so master 0 wins the first arbitration.
  - rst asserted mid-transfer aborts it: p_sel/p_ce drop the next cycle and no m_done is issued.
- States: IDLE, SETUP, ACCESS, DONE (one-hot or binary; encoding constant in the package).
- IDLE:
  - If any m_req bit is high, grant the first requesting index after the last-grant pointer (circular).
  - Register that master's we/addr/wdata/strb onto p_*, update the pointer, go to SETUP.
  - m_req is sampled only in IDLE.
- SETUP: p_sel=1, p_ce=0 for exactly one cycle, then ACCESS.
- ACCESS:
  - p_sel=1, p_ce=1.
  - On p_rdy=1: capture p_rdata into m_rdata (writes capture as well; the value is don't-care) and go to DONE.
  - p_rdy low: hold; p_addr/p_wdata/p_strb/p_we stay stable.
- DONE:
  - p_sel=0, p_ce=0.
  - m_done[grant]=1 for one cycle, m_rdata held; next state IDLE.
- Latency: m_req high in IDLE at cycle T -> SETUP T+1, ACCESS T+2; with p_rdy=1 at T+2, m_done at T+3. Minimum 4 cycles per transfer.
- Master contract:
  - Hold m_req and command fields stable until m_done.
  - Drop m_req on the edge where m_done is seen, so a registered master's m_req is low in the following IDLE cycle.
  - m_req still high in that IDLE cycle counts as a new request.
- Fairness:
  - With all masters requesting continuously, grants rotate 0,1,...,NM-1,0.
  - No master waits more than NM-1 transfers.
- Requests that change while not in IDLE are ignored; only registered copies drive the bus.
- m_rdata is held between transfers (not cleared).

Optional Feature:
- Macro: PGR_APB_ARB_TIMEOUT_EN.
- Defined:
  - An ACCESS cycle counter is cleared on entry to ACCESS.
  - If it reaches TO_CYCLES-1 with p_rdy still low, go to DONE.
  - In DONE: m_done and m_err pulse for the granted master, and m_rdata = ERR_RDATA (32'hDEAD_BEEF, truncated/zero-extended to DW).
  - p_rdy and the timeout in the same cycle: p_rdy wins, no error.
- Undefined: no counter; ACCESS waits indefinitely; m_err is tied 0.

Decomposition:
- Package pgr_apb_arb_pkg holds:
  - state encoding localparams (ST_IDLE, ST_SETUP, ST_ACCESS, ST_DONE);
  - ERR_RDATA;
  - the default TO_CYCLES.
- One sub-module, pgr_rr_arb: combinational round-robin picker.
  - Inputs: req[NM], last[$clog2(NM)].
  - Outputs: gnt_idx, gnt_vld.
  - Instantiated once; the pointer register stays in the top level.

Test Plan:
- Single read: m_req=01, m_addr0=16'h0010, m_we=0; p_rdy=1 on the first ACCESS cycle with p_rdata=32'h1234_5678 -> p_sel high 2 cycles, m_done=01 at T+3, m_rdata=32'h1234_5678.
- Write with wait states: m1 write addr=16'h0200, wdata=32'hA5A5_0F0F, strb=4'b0011; p_rdy delayed 5 cycles -> p_* stable throughout ACCESS, m_done=10 exactly once, after 9 cycles total.
- Contention: both masters request continuously for 6 transfers -> grant order 0,1,0,1,0,1; never two consecutive grants to one master.
- Reset mid-ACCESS: rst pulsed for 1 cycle during ACCESS -> all outputs 0 the next cycle, no m_done; the next request from master 1 still loses to simultaneous master 0 (pointer reset).
- Timeout (macro defined, TO_CYCLES=16): p_rdy held low -> m_done and m_err pulse after 16 ACCESS cycles, m_rdata=32'hDEAD_BEEF; without the macro, the bus is still in ACCESS at cycle 100.
- p_rdy coincident with the final timeout cycle (macro defined) -> m_err=0 and m_rdata=p_rdata.
